// File: rtl/gb_cart_pkg.sv
// Shared types and constants for the Game Boy cartridge memory arbiter.
package gb_cart_pkg;

  localparam int CART_ADDR_W = 24;

  // Bit positions of each requester in the pending vector
  localparam int P_CPU = 0;
  localparam int P_SAV = 1;
  localparam int P_LDR = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } cart_state_e;

  typedef enum logic [1:0] {
    RID_CPU  = 2'd0,
    RID_SAV  = 2'd1,
    RID_LDR  = 2'd2,
    RID_NONE = 2'd3
  } req_id_e;

endpackage

// File: rtl/gb_cart_arb_pick.sv
// Grant selection: CPU first, then save, then loader, with a starvation
// counter that forces a lower grant after STARVE_LIMIT back-to-back CPU wins.
module gb_cart_arb_pick
  import gb_cart_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [2:0] pend_i,
  input  logic       grant_i,
  output req_id_e    winner_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q, cnt_d;
  logic       lower_pend;
  logic       starved;

  assign lower_pend = pend_i[P_SAV] | pend_i[P_LDR];
  assign starved    = lower_pend && (cnt_q == LIMIT);

  always_comb begin
    winner_o = RID_NONE;
    if (pend_i[P_CPU] && !starved) winner_o = RID_CPU;
    else if (pend_i[P_SAV])        winner_o = RID_SAV;
    else if (pend_i[P_LDR])        winner_o = RID_LDR;
  end

  // Count only CPU wins that make someone else wait; any other grant resets it
  always_comb begin
    cnt_d = cnt_q;
    if (grant_i) begin
      if (winner_o == RID_CPU && lower_pend) cnt_d = cnt_q + 4'd1;
      else                                   cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gb_cart_mem_arb.sv
// External SRAM/PSRAM arbiter for CPU, loader and (with GB_CART_SAVE_PORT_EN)
// battery-save requesters; one IDLE/SETUP/ACCESS/HOLD transaction at a time.
module gb_cart_mem_arb
  import gb_cart_pkg::*;
#(
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [CART_ADDR_W-1:0] cpu_addr,
  input  logic [7:0]             cpu_wdata,
  output logic [7:0]             cpu_rdata,
  output logic                   cpu_ack,
  input  logic                   ldr_req,
  input  logic                   ldr_we,
  input  logic [CART_ADDR_W-1:0] ldr_addr,
  input  logic [7:0]             ldr_wdata,
  output logic [7:0]             ldr_rdata,
  output logic                   ldr_ack,
`ifdef GB_CART_SAVE_PORT_EN
  input  logic                   sav_req,
  input  logic                   sav_we,
  input  logic [CART_ADDR_W-1:0] sav_addr,
  input  logic [7:0]             sav_wdata,
  output logic [7:0]             sav_rdata,
  output logic                   sav_ack,
`endif
  output logic [CART_ADDR_W-1:0] mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata,
  output logic                   mem_ce_n,
  output logic                   mem_oe_n,
  output logic                   mem_we_n,
  output logic                   busy
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  cart_state_e            state_q, state_d;
  logic [3:0]             wcnt_q, wcnt_d;
  req_id_e                gnt_q;
  logic [CART_ADDR_W-1:0] addr_q;
  logic                   we_q;
  logic [7:0]             wdata_q;
  logic [7:0]             cpu_rdata_q, ldr_rdata_q;
`ifdef GB_CART_SAVE_PORT_EN
  logic [7:0]             sav_rdata_q;
`endif

  logic [2:0]             pend;
  req_id_e                winner;
  logic                   grant;
  logic                   last_access;
  logic [CART_ADDR_W-1:0] sel_addr;
  logic                   sel_we;
  logic [7:0]             sel_wdata;

`ifdef GB_CART_SAVE_PORT_EN
  assign pend = {ldr_req, sav_req, cpu_req};
`else
  assign pend = {ldr_req, 1'b0, cpu_req};
`endif

  assign grant       = (state_q == ST_IDLE) && (winner != RID_NONE);
  assign last_access = (state_q == ST_ACCESS) && (wcnt_q == WAIT_LAST);

  gb_cart_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clock   (clock),
    .rst_n   (rst_n),
    .pend_i  (pend),
    .grant_i (grant),
    .winner_o(winner)
  );

  always_comb begin
    sel_addr  = cpu_addr;
    sel_we    = cpu_we;
    sel_wdata = cpu_wdata;
    unique case (winner)
      RID_LDR: begin
        sel_addr  = ldr_addr;
        sel_we    = ldr_we;
        sel_wdata = ldr_wdata;
      end
`ifdef GB_CART_SAVE_PORT_EN
      RID_SAV: begin
        sel_addr  = sav_addr;
        sel_we    = sav_we;
        sel_wdata = sav_wdata;
      end
`endif
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (last_access) state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == ST_SETUP)       wcnt_d = '0;
    else if (state_q == ST_ACCESS) wcnt_d = wcnt_q + 4'd1;
  end

  // Request latch and read-data capture
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      gnt_q       <= RID_NONE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
`ifdef GB_CART_SAVE_PORT_EN
      sav_rdata_q <= '0;
`endif
    end else begin
      wcnt_q <= wcnt_d;
      if (grant) begin
        gnt_q   <= winner;
        addr_q  <= sel_addr;
        we_q    <= sel_we;
        wdata_q <= sel_wdata;
      end
      if (last_access && !we_q) begin
        unique case (gnt_q)
          RID_CPU: cpu_rdata_q <= mem_rdata;
          RID_LDR: ldr_rdata_q <= mem_rdata;
`ifdef GB_CART_SAVE_PORT_EN
          RID_SAV: sav_rdata_q <= mem_rdata;
`endif
          default: ;
        endcase
      end
    end
  end

  // Output decode
  always_comb begin
    mem_ce_n = 1'b1;
    mem_oe_n = 1'b1;
    mem_we_n = 1'b1;
    cpu_ack  = 1'b0;
    ldr_ack  = 1'b0;
`ifdef GB_CART_SAVE_PORT_EN
    sav_ack  = 1'b0;
`endif
    unique case (state_q)
      ST_SETUP: mem_ce_n = 1'b0;
      ST_ACCESS: begin
        mem_ce_n = 1'b0;
        mem_oe_n = we_q;
        mem_we_n = !we_q;
      end
      ST_HOLD: begin
        mem_ce_n = 1'b0;
        cpu_ack  = (gnt_q == RID_CPU);
        ldr_ack  = (gnt_q == RID_LDR);
`ifdef GB_CART_SAVE_PORT_EN
        sav_ack  = (gnt_q == RID_SAV);
`endif
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
`ifdef GB_CART_SAVE_PORT_EN
  assign sav_rdata = sav_rdata_q;
`endif

endmodule

// File: tb/tb_gb_cart_mem_arb.sv
// Directed bench for gb_cart_mem_arb (WAIT_CYCLES=2, STARVE_LIMIT=4).
module tb_gb_cart_mem_arb;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [23:0] cpu_addr, ldr_addr, mem_addr;
  logic [7:0]  cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata;
  logic        cpu_ack, ldr_ack;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ce_n, mem_oe_n, mem_we_n, busy;
`ifdef GB_CART_SAVE_PORT_EN
  logic        sav_req = 1'b0, sav_we = 1'b0, sav_ack;
  logic [23:0] sav_addr = '0;
  logic [7:0]  sav_wdata = '0, sav_rdata;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  gb_cart_mem_arb #(
    .WAIT_CYCLES (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .ldr_req  (ldr_req),
    .ldr_we   (ldr_we),
    .ldr_addr (ldr_addr),
    .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata),
    .ldr_ack  (ldr_ack),
`ifdef GB_CART_SAVE_PORT_EN
    .sav_req  (sav_req),
    .sav_we   (sav_we),
    .sav_addr (sav_addr),
    .sav_wdata(sav_wdata),
    .sav_rdata(sav_rdata),
    .sav_ack  (sav_ack),
`endif
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ce_n (mem_ce_n),
    .mem_oe_n (mem_oe_n),
    .mem_we_n (mem_we_n),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int we_low, oe_low, wd_ok, la, ca, ack_c, n_ack;
    int ids[10];
    int cyc[10];
    int aid[2];
    int acyc[2];

    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ce_n", mem_ce_n, 1);
    check("rst_oe_n", mem_oe_n, 1);
    check("rst_we_n", mem_we_n, 1);
    check("rst_busy", busy, 0);
    check("rst_acks", {cpu_ack, ldr_ack}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_ce_n", mem_ce_n, 1);

    // CPU read 0x004123 -> oe low cycles 2-3, ack cycle 4
    cpu_req = 1; cpu_we = 0; cpu_addr = 24'h004123; mem_rdata = 8'h5A;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      check($sformatf("rd_oe_c%0d", c), mem_oe_n, (c == 2 || c == 3) ? 0 : 1);
      check($sformatf("rd_ack_c%0d", c), cpu_ack, (c == 4) ? 1 : 0);
      check($sformatf("rd_ce_c%0d", c), mem_ce_n, (c <= 4) ? 0 : 1);
      check($sformatf("rd_busy_c%0d", c), busy, (c <= 4) ? 1 : 0);
      if (c == 2) check("rd_addr_latched", mem_addr, 24'h004123);
      if (c == 1) begin cpu_req = 0; cpu_addr = 24'hFFFFFF; end
    end
    check("rd_cpu_rdata", cpu_rdata, 8'h5A);
    check("rd_ldr_rdata", ldr_rdata, 8'h00);
    mem_rdata = 8'h00;
    repeat (2) @(negedge clock);
    check("rd_rdata_hold", cpu_rdata, 8'h5A);

    // Loader write 0x010000 / 0xC3
    ldr_req = 1; ldr_we = 1; ldr_addr = 24'h010000; ldr_wdata = 8'hC3;
    we_low = 0; oe_low = 0; wd_ok = 1; la = 0; ca = 0; ack_c = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (!mem_we_n) begin
        we_low++;
        if (mem_wdata != 8'hC3 || mem_addr != 24'h010000) wd_ok = 0;
      end
      if (!mem_oe_n) oe_low++;
      if (ldr_ack) begin la++; ack_c = c; end
      if (cpu_ack) ca++;
      if (c == 1) begin ldr_req = 0; ldr_wdata = 8'h00; end
    end
    check("wr_we_low_cycles", we_low, 2);
    check("wr_oe_low_cycles", oe_low, 0);
    check("wr_wdata_ok", wd_ok, 1);
    check("wr_ldr_ack_count", la, 1);
    check("wr_ldr_ack_cycle", ack_c, 4);
    check("wr_cpu_ack_count", ca, 0);
    check("wr_cpu_rdata_kept", cpu_rdata, 8'h5A);

    // Simultaneous requests: CPU first, loader on the next IDLE
    cpu_req = 1; cpu_we = 0; cpu_addr = 24'h000100;
    ldr_req = 1; ldr_we = 0; ldr_addr = 24'h000200; mem_rdata = 8'h77;
    n_ack = 0; aid[0] = 0; aid[1] = 0; acyc[0] = 0; acyc[1] = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clock);
      if ((cpu_ack || ldr_ack) && n_ack < 2) begin
        aid[n_ack]  = cpu_ack ? (ldr_ack ? 3 : 1) : 2;
        acyc[n_ack] = c;
        n_ack++;
      end
      if (c == 1) cpu_req = 0;
      if (ldr_ack) ldr_req = 0;
    end
    check("sim_first_id", aid[0], 1);
    check("sim_first_cyc", acyc[0], 4);
    check("sim_second_id", aid[1], 2);
    check("sim_second_cyc", acyc[1], 9);
    check("sim_ldr_rdata", ldr_rdata, 8'h77);

    // Both held: CPU x4 then loader, one access every 5 cycles
    cpu_req = 1; ldr_req = 1;
    na_init: begin
      for (int i = 0; i < 10; i++) begin ids[i] = 0; cyc[i] = 0; end
    end
    n_ack = 0;
    for (int c = 1; c <= 60 && n_ack < 10; c++) begin
      @(negedge clock);
      if (cpu_ack || ldr_ack) begin
        ids[n_ack] = cpu_ack ? (ldr_ack ? 3 : 1) : 2;
        cyc[n_ack] = c;
        n_ack++;
        if (n_ack == 10) begin cpu_req = 0; ldr_req = 0; end
      end
    end
    check("stv_n_acks", n_ack, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stv_id%0d", i), ids[i], (i % 5 == 4) ? 2 : 1);
      check($sformatf("stv_cyc%0d", i), cyc[i], 4 + 5 * i);
    end

    // Reset during ACCESS of a write, then the held request completes
    repeat (2) @(negedge clock);
    cpu_req = 1; cpu_we = 1; cpu_addr = 24'h000777; cpu_wdata = 8'h11;
    repeat (2) @(negedge clock);
    check("arst_pre_we", mem_we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we_n", mem_we_n, 1);
    check("arst_ce_n", mem_ce_n, 1);
    check("arst_busy", busy, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_rdata", cpu_rdata, 0);
    @(negedge clock);
    check("arst_no_ack", {cpu_ack, ldr_ack}, 0);
    rst_n = 1'b1;
    we_low = 0; wd_ok = 1; ca = 0; ack_c = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (!mem_we_n) begin
        we_low++;
        if (mem_wdata != 8'h11 || mem_addr != 24'h000777) wd_ok = 0;
      end
      if (cpu_ack) begin ca++; ack_c = c; end
      if (c == 1) cpu_req = 0;
    end
    check("arst_after_we_low", we_low, 2);
    check("arst_after_wdata", wd_ok, 1);
    check("arst_after_ack_n", ca, 1);
    check("arst_after_ack_c", ack_c, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gb_cart_mem_arb.md
GB_CART_MEM_ARB -- requirements
Module: gb_cart_mem_arb

Interface
REQ-001 SHALL have parameters: WAIT_CYCLES, default 2, external SRAM strobe-active cycles per access (1..15); STARVE_LIMIT, default 4, consecutive CPU grants allowed while a lower requester waits (1..15).
REQ-002 SHALL have port clock  in  1  single clock for all sequential logic.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in 24, cpu_wdata in 8: GB-side access request using the translated cartridge address.
REQ-005 SHALL have ports cpu_rdata out 8 and cpu_ack out 1: read data and one-cycle completion pulse.
REQ-006 SHALL have ports ldr_req, ldr_we, ldr_addr[23:0], ldr_wdata[7:0] in, and ldr_rdata[7:0], ldr_ack out: ROM-image loader port, same semantics as CPU port.
REQ-007 SHALL have ports mem_addr out 24, mem_wdata out 8, mem_rdata in 8, mem_ce_n out 1, mem_oe_n out 1, mem_we_n out 1: external SRAM/PSRAM.
REQ-008 SHALL have port busy out 1: high whenever the FSM is not IDLE.

Function
REQ-009 SHALL sequence FSM states IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_CYCLES cycles) -> HOLD (1 cycle) -> IDLE.
REQ-010 SHALL arbitrate only in IDLE; with no pending req, SHALL remain in IDLE.
REQ-011 SHALL latch addr, we and wdata of the granted requester on the IDLE->SETUP edge; later requester input changes SHALL not affect the access.
REQ-012 SHALL drive mem_addr from the latch and mem_ce_n=0 in SETUP, ACCESS and HOLD; mem_ce_n=1 in IDLE.
REQ-013 SHALL drive mem_oe_n=0 (read) or mem_we_n=0 with mem_wdata valid (write) only during ACCESS.
REQ-014 SHALL capture mem_rdata on the last ACCESS cycle into the granted port's rdata; rdata SHALL hold until that port's next read completes.
REQ-015 SHALL pulse exactly one ack for exactly one cycle, in HOLD, to the granted requester only; req sampled in IDLE with ack at cycle WAIT_CYCLES+2.
REQ-016 SHALL ignore req during SETUP/ACCESS/HOLD; a continuously held req SHALL yield one access per WAIT_CYCLES+3 cycles.
REQ-017 SHALL give CPU fixed priority over loader (and save port when compiled in), except REQ-018.
REQ-018 SHALL count consecutive CPU grants while any lower requester is pending; when count equals STARVE_LIMIT, the next grant SHALL go to the highest-priority pending non-CPU requester, clearing the count.
REQ-019 SHALL clear the starvation count on any non-CPU grant or when no lower requester is pending at a CPU grant.

Reset
REQ-020 SHALL, on rst_n low, immediately (asynchronously) force IDLE, mem_ce_n=mem_oe_n=mem_we_n=1, all ack=0, busy=0, starvation count=0, mem_addr=0, mem_wdata=0, all rdata=0.
REQ-021 SHALL abort any access in progress on reset with no ack issued; after rst_n rises, first arbitration SHALL occur in the first IDLE cycle.

Configuration
REQ-022 SHALL, with GB_CART_SAVE_PORT_EN defined, add port sav_req/sav_we/sav_addr[23:0]/sav_wdata[7:0] in, sav_rdata[7:0]/sav_ack out (battery-RAM backup engine), priority CPU > save > loader, starvation rule applying to both.
REQ-023 SHALL, without GB_CART_SAVE_PORT_EN, omit the sav_* ports and all related logic entirely.

Structure
REQ-024 SHALL place the FSM state enum, requester-ID enum and CART_ADDR_W=24 constant in shared package gb_cart_pkg.
REQ-025 SHALL implement grant selection plus starvation counter in sub-module gb_cart_arb_pick (inputs: pending reqs, grant strobe; output: winner ID).

Verification
REQ-026 CPU read 0x004123, WAIT_CYCLES=2, mem_rdata=0x5A -> mem_oe_n low cycles 2-3, cpu_ack at cycle 4, cpu_rdata=0x5A.
REQ-027 Loader write 0x010000 data 0xC3 -> mem_we_n low exactly 2 cycles with mem_wdata=0xC3, ldr_ack one cycle, no cpu_ack.
REQ-028 cpu_req and ldr_req held continuously, STARVE_LIMIT=4 -> grant sequence CPU,CPU,CPU,CPU,LDR repeating; each access 5 cycles apart.
REQ-029 Simultaneous cpu_req and ldr_req in IDLE after idle period -> CPU granted first, loader granted next IDLE.
REQ-030 rst_n low during ACCESS of a write -> mem_we_n/mem_ce_n high same cycle, no ack; after release, pending req completes normally.
REQ-031 With GB_CART_SAVE_PORT_EN, sav_req and ldr_req together, no CPU -> save granted before loader.
